// File: rtl/stopwatch_disp_mux_if.sv
// Digit inputs and display-pin outputs of the stopwatch seven-segment scanner.
// The driver of the digits (counter stage / bench) uses master; the scanner uses slave.
interface stopwatch_disp_mux_if;
    logic [3:0] i_s2;
    logic [3:0] i_s1;
    logic [3:0] i_s0;
    logic       i_hold;
    logic [3:0] o_an;
    logic [7:0] o_sseg;
    logic       o_frame;

    modport master (
        output i_s2, i_s1, i_s0, i_hold,
        input  o_an, o_sseg, o_frame
    );

    modport slave (
        input  i_s2, i_s1, i_s0, i_hold,
        output o_an, o_sseg, o_frame
    );
endinterface

// File: rtl/stopwatch_disp_mux.sv
// Four-digit multiplexed seven-segment driver showing "_XX.X" from a per-frame digit snapshot.
// Optional build macro LZ_BLANK_EN blanks the tens-of-seconds digit when it is zero.
module stopwatch_disp_mux #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    stopwatch_disp_mux_if.slave  bus
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap_s2_q, snap_s2_d;
    logic [3:0]    snap_s1_q, snap_s1_d;
    logic [3:0]    snap_s0_q, snap_s0_d;
    logic          bnd_q, bnd_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          frame_q;
    logic          wrap;
    logic [3:0]    digit;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_s2_q <= '0;
            snap_s1_q <= '0;
            snap_s0_q <= '0;
            bnd_q     <= 1'b0;
            an_q      <= 4'hF;
            sseg_q    <= 8'hFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_s2_q <= snap_s2_d;
            snap_s1_q <= snap_s1_d;
            snap_s0_q <= snap_s0_d;
            bnd_q     <= bnd_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
            // Delayed by one so the pulse coincides with the new digit reaching the pins.
            frame_q   <= bnd_q;
        end
    end

    always_comb begin
        wrap      = (cnt_q == CNT_MAX);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        bnd_d     = wrap && (idx_q == 2'd3);
        snap_s2_d = snap_s2_q;
        snap_s1_d = snap_s1_q;
        snap_s0_d = snap_s0_q;
        if (bnd_d && !bus.i_hold) begin
            snap_s2_d = bus.i_s2;
            snap_s1_d = bus.i_s1;
            snap_s0_d = bus.i_s0;
        end
    end

    always_comb begin
        an_d   = ~(4'b0001 << idx_q);
        digit  = snap_s0_q;
        sseg_d = 8'hFF;
        case (idx_q)
            2'd0: begin
                digit  = snap_s0_q;
                sseg_d = seg7(digit);
            end
            2'd1: begin
                digit  = snap_s1_q;
                sseg_d = seg7(digit) & 8'h7F;
            end
            2'd2: begin
                digit  = snap_s2_q;
`ifdef LZ_BLANK_EN
                sseg_d = (digit == 4'd0) ? 8'hFF : seg7(digit);
`else
                sseg_d = seg7(digit);
`endif
            end
            default: sseg_d = 8'hFF;
        endcase
    end

    assign bus.o_an    = an_q;
    assign bus.o_sseg  = sseg_q;
    assign bus.o_frame = frame_q;
endmodule

// File: doc/stopwatch_disp_mux.md
# stopwatch_disp_mux

Time-multiplexed 4-digit seven-segment driver for the stopwatch's three BCD digits (tens of seconds, seconds, tenths), displayed as "_XX.X". Sits directly downstream of the stopwatch counter stage and drives the board's anode and segment pins. Input digits are snapshotted once per scan frame so a frame never mixes old and new counts. A hold input freezes the shown value for lap display.

## Interface
Parameters:
- REFRESH_DIV, 100_000: clock cycles each digit stays lit (1 ms at 100 MHz). Legal range ≥ 2; counter width $clog2(REFRESH_DIV).

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_s2  in  4  BCD tens of seconds.
- i_s1  in  4  BCD seconds.
- i_s0  in  4  BCD tenths.
- i_hold  in  1  1 = skip snapshot reloads (freeze display).
- o_an  out  4  anode enables, active-low, one-hot-low.
- o_sseg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- o_frame  out  1  one-cycle pulse at each frame boundary.

## Operation
- Refresh counter cnt counts 0..REFRESH_DIV-1 and wraps. On cnt == REFRESH_DIV-1, scan index idx advances 0→1→2→3→0.
- Frame boundary: the cycle with idx==3 and cnt==REFRESH_DIV-1. In that cycle:
  - snap_s2/s1/s0 load i_s2/i_s1/i_s0 unless i_hold==1.
  - o_frame is asserted on the following edge, regardless of i_hold.
- Digit mapping:
  - idx0 → snap_s0.
  - idx1 → snap_s1 with dp lit (bit7 = 0).
  - idx2 → snap_s2.
  - idx3 → blank (0xFF).
- o_an = ~(4'b0001 << idx).
- Decode, active-low, dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- Non-BCD digit values 10–15 render as '-' (0xBF); with dp on idx1 this becomes 0x3F.
- i_hold is sampled only at frame boundaries. Toggling it mid-frame has no visible effect.

## Timing
- Reset (async, while i_rst_n=0):
  - cnt=0, idx=0, snap_*=0.
  - o_an=4'b1111, o_sseg=8'hFF, o_frame=0.
  - Assertion mid-scan clears all outputs immediately, without waiting for a clock.
- o_an and o_sseg are registered: pins reflect the scan state and snapshot of the previous cycle (1-cycle latency).
- First edge after reset release: o_an=1110, showing snap_s0 = 0.
- Each digit is lit for exactly REFRESH_DIV consecutive cycles. One frame = 4·REFRESH_DIV cycles.
- Snapshot to visible latency: the new snap_s0 appears on the pins on the same edge that o_frame rises, i.e. the first cycle of the idx0 display window.
- Inputs changing in the same cycle as the frame boundary are captured (sampled on that edge).
- o_frame is high for exactly one cycle per frame and never during reset.

## Configuration
- LZ_BLANK_EN:
  - Defined: idx2 is blanked (0xFF) when snap_s2==0. idx1 is never blanked, so 0 seconds shows "0.".
  - Undefined: idx2 always shows its digit (0 → C0).
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use REFRESH_DIV=4.
1. Reset: hold i_rst_n=0 for 10 cycles, then assert it again mid-idx2 → o_an=1111, o_sseg=FF and o_frame=0 immediately both times; after release, o_an=1110 and o_sseg=C0.
2. Scan sequence: i_s2=4, i_s1=2, i_s0=7, run past the first o_frame → repeating 4-cycle windows: o_an=1110/F8, 1101/24, 1011/99, 0111/FF; o_frame period 16 cycles.
3. Coherency: change inputs to 9,9,9 at cycle 6 of a frame → all three digits keep 4,2,7 until the next o_frame, then show 90, 10, 90 together.
4. Hold: i_hold=1 across two frame boundaries while inputs change → o_frame still pulses every 16 cycles and digits stay unchanged. Drop i_hold → digits update at the next boundary.
5. Invalid BCD: i_s0=4'hC, i_s1=4'hF → idx0 window shows BF, idx1 window shows 3F.
6. Blanking: i_s2=0, i_s1=0, i_s0=5 → with LZ_BLANK_EN, idx2 window shows FF and idx1 shows 40; without it, idx2 shows C0.
